keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//   Input-side counterpart of the 4-digit seven-segment display multiplexer. It scans a 4x4 matrix
//   keypad by driving one active-low column strobe at a time and sampling the active-low row lines.
//   It debounces the result and emits one 4-bit key code with a single-cycle valid pulse per press.
//   It sits on the 25 MHz board clock between the keypad pins and the lab FSM datapath.
// PARAMETERS
//   SCAN_BITS     17  scan counter width; column dwell = 2^(SCAN_BITS-2) clk (1.31 ms @25 MHz)
//   DEBOUNCE      4   consecutive identical full scans required for press and release (>=1, <=15)
//   REPEAT_SCANS  32  full scans between auto-repeat pulses (used only with KEYPAD_REPEAT_EN)
// PORTS
//   clk        in   1  25 MHz clock
//   rst        in   1  synchronous reset, active-low: sampled on posedge clk, clears when 0
//   row        in   4  keypad rows, active-low (external pull-ups); row[r]=0 means pressed in strobed column
//   col        out  4  column strobes, active-low, exactly one bit low when out of reset
//   key_code   out  4  debounced key index = 4*c + r (c = strobed column, r = row)
//   key_valid  out  1  one-clk pulse when a new debounced press is accepted
//   key_held   out  1  high from the key_valid cycle until the debounced release completes
// BEHAVIOUR
//   Reset (rst==0 at posedge): cnt=0, col=4'b1111, key_code=0, key_valid=0, key_held=0, FSM=IDLE, snapshot=0.
//   Scan: cnt increments every clk and wraps at 2^SCAN_BITS.
//     - cnt[top:top-1] = 00/01/10/11 selects col = 1110/1101/1011/0111 (registered).
//   Sampling: row is read only when cnt[SCAN_BITS-3:0] is all ones (last dwell cycle, lines settled).
//     - For the strobed column c, snap[4c+r] <= ~row[r].
//   scan_done: one-cycle strobe on the column-3 sample. It evaluates the full 16-bit snapshot.
//     - any = |snap; key = lowest set index (lowest index wins on multi-key).
//   FSM, advanced only on scan_done:
//     - IDLE: any -> DEBOUNCE, cand=key, dcnt=1. If DEBOUNCE==1, go directly to PRESSED.
//     - DEBOUNCE: any && key==cand -> dcnt+1; reaching DEBOUNCE -> PRESSED. Otherwise -> IDLE, dcnt=0.
//     - PRESSED (entry): key_code<=cand; key_valid=1 for exactly the clk after that scan_done; key_held=1.
//     - PRESSED: snap[cand]==0 -> RELEASE, rcnt=1. Other keys pressed meanwhile are ignored.
//     - RELEASE: snap[cand]==0 -> rcnt+1; reaching DEBOUNCE -> IDLE, key_held=0.
//       snap[cand]==1 -> back to PRESSED with no new key_valid.
//   Latency: key_valid occurs 1 clk after the DEBOUNCE-th consistent scan_done.
//   key_code holds its last value after release. It is only updated at PRESSED entry.
//   Reset mid-scan or mid-debounce aborts everything; no key_valid is emitted during or after reset.
//   A counter wrap is seamless: column 0 follows column 3 with no gap cycle.
// CONFIGURATION
//   KEYPAD_REPEAT_EN defined: while in PRESSED, a 5-bit rep counter counts scan_done.
//     - Every REPEAT_SCANS scans it re-pulses key_valid (one clk) with the same key_code.
//     - rep clears on PRESSED entry and on RELEASE->PRESSED.
//   KEYPAD_REPEAT_EN undefined: exactly one key_valid per debounced press; the rep logic is absent.
// TESTING (SCAN_BITS=6: dwell 16 clk, full scan 64 clk; DEBOUNCE=4)
//   1 Hold rst=0 for 3 clk -> col=1111, key_valid=0, key_held=0, key_code=0.
//     Then rst=1 -> col=1110 the next clk, 1101 16 clk later.
//   2 Hold row[2]=0 whenever col[1]=0 (key 6) -> single key_valid pulse, key_code=6, key_held=1.
//     The pulse is 1 clk after the 4th scan_done.
//   3 Toggle key 6 every 40 clk for 400 clk, then release -> key_valid never asserts, key_held stays 0.
//   4 Press keys 9 and 3 together -> key_code=3, one pulse.
//     Then release 3 while holding 9 -> key_held=0 after 4 scans, no pulse for 9 until it is re-pressed.
//   5 Release key 6 for 2 scans then re-press -> key_held stays 1, no second pulse.
//     Also drive rst=0 while PRESSED -> all outputs at reset values the next clk.
//   6 KEYPAD_REPEAT_EN, REPEAT_SCANS=8, hold key 15 (row[3]=0 on col[3]=0) ->
//     key_valid at scan 4, then at scans 12, 20, 28; none once released.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad, debounces whole-keypad snapshots and
// emits one key code per press. Optional auto-repeat of key_valid: define KEYPAD_REPEAT_EN.
module keypad_scanner #(
  parameter int SCAN_BITS    = 17,
  parameter int DEBOUNCE     = 4,
  parameter int REPEAT_SCANS = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_PRESSED,
    S_RELEASE
  } state_t;

  localparam logic [3:0]           DEB_TARGET = 4'(DEBOUNCE);
  localparam logic [SCAN_BITS-1:0] CNT_ONE    = SCAN_BITS'(1);

  if (SCAN_BITS < 3) begin : g_bad_scan_bits
    $error("keypad_scanner: SCAN_BITS must be at least 3");
  end
  if (DEBOUNCE < 1 || DEBOUNCE > 15) begin : g_bad_debounce
    $error("keypad_scanner: DEBOUNCE must be in 1..15");
  end
  if (REPEAT_SCANS < 1 || REPEAT_SCANS > 32) begin : g_bad_repeat
    $error("keypad_scanner: REPEAT_SCANS must be in 1..32");
  end

  logic [SCAN_BITS-1:0] cnt;
  logic [1:0]           scan_col;
  logic                 sample;
  logic [15:0]          snap;
  logic                 scan_done;

  assign scan_col = cnt[SCAN_BITS-1 -: 2];
  assign sample   = &cnt[SCAN_BITS-3:0];

  // Rows are read on the last dwell cycle of each column so the strobe has settled.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt       <= '0;
      col       <= 4'b1111;
      snap      <= '0;
      scan_done <= 1'b0;
    end else begin
      cnt       <= cnt + CNT_ONE;
      col       <= ~(4'b0001 << scan_col);
      scan_done <= sample && (scan_col == 2'd3);
      if (sample) begin
        snap[{scan_col, 2'b00} +: 4] <= ~row;
      end
    end
  end

  logic [3:0] first_key;
  logic       any_key;
  logic       cand_hit;

  state_t     state, state_n;
  logic [3:0] cand, cand_n;
  logic [3:0] dcnt, dcnt_n;
  logic       lockout, lockout_n;
  logic [3:0] code_n;
  logic       valid_n;
  logic       held_n;
  logic       accept;
  logic [3:0] accept_key;
  logic       release_done;
`ifdef KEYPAD_REPEAT_EN
  localparam logic [4:0] REP_LAST = 5'(REPEAT_SCANS - 1);
  logic [4:0] rep, rep_n;
`endif

  assign any_key  = |snap;
  assign cand_hit = snap[cand];

  // NOTE: every always_comb output is given a default first, so no path can infer a latch.
  always_comb begin
    first_key = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (snap[i]) first_key = 4'(i);
    end
  end

  // After a release completes with other keys still down, those keys stay ignored until the
  // keypad has been seen completely empty, so a key held through another press never fires.
  always_comb begin
    state_n      = state;
    cand_n       = cand;
    dcnt_n       = dcnt;
    lockout_n    = lockout;
    code_n       = key_code;
    valid_n      = 1'b0;
    held_n       = key_held;
    accept       = 1'b0;
    accept_key   = cand;
    release_done = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_n        = rep;
`endif
    if (scan_done) begin
      case (state)
        S_IDLE: begin
          if (!any_key) begin
            lockout_n = 1'b0;
          end else if (!lockout) begin
            cand_n     = first_key;
            dcnt_n     = 4'd1;
            state_n    = S_DEBOUNCE;
            accept_key = first_key;
            accept     = (DEB_TARGET == 4'd1);
          end
        end
        S_DEBOUNCE: begin
          if (any_key && first_key == cand) begin
            dcnt_n = dcnt + 4'd1;
            accept = (dcnt_n == DEB_TARGET);
          end else begin
            state_n = S_IDLE;
            dcnt_n  = 4'd0;
          end
        end
        S_PRESSED: begin
          if (!cand_hit) begin
            state_n      = S_RELEASE;
            dcnt_n       = 4'd1;
            release_done = (DEB_TARGET == 4'd1);
          end
`ifdef KEYPAD_REPEAT_EN
          else if (rep == REP_LAST) begin
            rep_n   = '0;
            valid_n = 1'b1;
          end else begin
            rep_n = rep + 5'd1;
          end
`endif
        end
        S_RELEASE: begin
          if (!cand_hit) begin
            dcnt_n       = dcnt + 4'd1;
            release_done = (dcnt_n == DEB_TARGET);
          end else begin
            state_n = S_PRESSED;
            dcnt_n  = 4'd0;
`ifdef KEYPAD_REPEAT_EN
            rep_n   = '0;
`endif
          end
        end
        default: state_n = S_IDLE;
      endcase

      if (accept) begin
        state_n = S_PRESSED;
        code_n  = accept_key;
        valid_n = 1'b1;
        held_n  = 1'b1;
        dcnt_n  = 4'd0;
`ifdef KEYPAD_REPEAT_EN
        rep_n   = '0;
`endif
      end
      if (release_done) begin
        state_n   = S_IDLE;
        held_n    = 1'b0;
        dcnt_n    = 4'd0;
        lockout_n = any_key;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      cand      <= 4'd0;
      dcnt      <= 4'd0;
      lockout   <= 1'b0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep       <= '0;
`endif
    end else begin
      state     <= state_n;
      cand      <= cand_n;
      dcnt      <= dcnt_n;
      lockout   <= lockout_n;
      key_code  <= code_n;
      key_valid <= valid_n;
      key_held  <= held_n;
`ifdef KEYPAD_REPEAT_EN
      rep       <= rep_n;
`endif
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: randomized keypad stimulus against a per-scan reference model with a
// key_valid scoreboard (SCAN_BITS=6, DEBOUNCE=4, REPEAT_SCANS=8).
module tb_keypad_scanner;

  localparam int SCAN_BITS = 6;
  localparam int DEB       = 4;
  localparam int REP       = 8;
  localparam int DWELL     = 16;
  localparam int SCAN      = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] keys = '0;

  keypad_scanner #(
    .SCAN_BITS   (SCAN_BITS),
    .DEBOUNCE    (DEB),
    .REPEAT_SCANS(REP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .row      (row),
    .col      (col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key pulls its row low while its column is strobed.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!col[c] && keys[4*c+r]) row[r] = 1'b0;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int n        = 0;   // clock edges since reset release
  int pulses   = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, n);
    end
  endtask

  typedef struct {
    int key;
    int due;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: one step per complete keypad scan.
  logic [15:0] m_snap;
  bit          m_held;
  bit          m_lock;
  int          m_cand, m_press_run, m_rel_run, m_rep, m_code;

  task automatic model_reset();
    m_snap = '0; m_held = 0; m_lock = 0;
    m_cand = 0; m_press_run = 0; m_rel_run = 0; m_rep = 0; m_code = 0;
    exp_q.delete();
  endtask

  task automatic scan_step(input int due);
    int lowest;
    bit any;
    any    = (m_snap != 0);
    lowest = -1;
    for (int i = 15; i >= 0; i--) if (m_snap[i]) lowest = i;
    if (!m_held) begin
      if (m_press_run == 0) begin
        if (!any) m_lock = 0;
        else if (!m_lock) begin
          m_cand = lowest;
          m_press_run = 1;
        end
      end else if (any && lowest == m_cand) m_press_run++;
      else m_press_run = 0;
      if (m_press_run == DEB) begin
        m_held = 1; m_code = m_cand; m_press_run = 0; m_rel_run = 0; m_rep = 0;
        exp_q.push_back('{m_code, due});
      end
    end else if (!m_snap[m_cand]) begin
      m_rel_run++;
      if (m_rel_run == DEB) begin
        m_held = 0; m_rel_run = 0; m_lock = any;
      end
    end else if (m_rel_run > 0) begin
      m_rel_run = 0; m_rep = 0;
    end else begin
`ifdef KEYPAD_REPEAT_EN
      m_rep++;
      if (m_rep == REP) begin
        m_rep = 0;
        exp_q.push_back('{m_code, due});
      end
`endif
    end
  endtask

  initial begin : model
    int c;
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst) begin
        n = 0;
        model_reset();
      end else begin
        n++;
        if ((n - 1) % DWELL == DWELL - 1) begin
          c = ((n - 1) / DWELL) % 4;
          m_snap[4*c +: 4] = keys[4*c +: 4];
          if (c == 3) scan_step(n + 1);
        end
      end
    end
  end

  initial begin : monitor
    exp_t       e;
    logic [3:0] exp_col;
    forever begin
      @(negedge clk);
      if (n > 0) begin
        if (key_valid) begin
          pulses++;
          if (exp_q.size() == 0) check("spurious key_valid", int'(key_valid), 0);
          else begin
            e = exp_q.pop_front();
            check("key_valid edge", n, e.due);
            check("key_valid code", int'(key_code), e.key);
          end
        end else if (exp_q.size() != 0 && exp_q[0].due <= n) begin
          e = exp_q.pop_front();
          check("missing key_valid", int'(key_valid), 1);
        end
        if (n % SCAN == 32) begin
          check("key_held", int'(key_held), int'(m_held));
          check("key_code hold", int'(key_code), m_code);
        end
        if (n % DWELL inside {0, 1, 8}) begin
          exp_col = 4'hF & ~(4'b0001 << (((n - 1) / DWELL) % 4));
          check("col strobe", int'(col), int'(exp_col));
        end
      end
    end
  end

  task automatic wait_scans(input int k);
    repeat (k * SCAN) @(negedge clk);
  endtask

  initial begin : stim
    int p0, k;
    rst  = 1'b0;
    keys = '0;
    repeat (3) @(negedge clk);
    check("reset col", int'(col), 4'b1111);
    check("reset key_valid", int'(key_valid), 0);
    check("reset key_held", int'(key_held), 0);
    check("reset key_code", int'(key_code), 0);
    rst = 1'b1;
    @(negedge clk);
    check("first col", int'(col), 4'b1110);
    repeat (16) @(negedge clk);
    check("second col", int'(col), 4'b1101);

    // Single press of key 6, then release.
    p0 = pulses;
    keys[6] = 1'b1;
    wait_scans(6);
    check("key6 pulses", pulses - p0, 1);
    check("key6 code", int'(key_code), 6);
    check("key6 held", int'(key_held), 1);
    keys = '0;
    wait_scans(6);
    check("key6 released", int'(key_held), 0);

    // Bounce: toggling every 40 clk never gives four consistent scans.
    p0 = pulses;
    repeat (10) begin
      keys[6] = ~keys[6];
      repeat (40) @(negedge clk);
    end
    keys = '0;
    wait_scans(6);
    check("bounce pulses", pulses - p0, 0);
    check("bounce held", int'(key_held), 0);

    // Keys 9 and 3 together: lowest index wins; 9 stays ignored after 3 is released.
    p0 = pulses;
    keys[9] = 1'b1;
    keys[3] = 1'b1;
    wait_scans(8);
    check("multi pulses", pulses - p0, 1);
    check("multi code", int'(key_code), 3);
    p0 = pulses;
    keys[3] = 1'b0;
    wait_scans(6);
    check("key3 released", int'(key_held), 0);
    wait_scans(4);
    check("key9 ignored", pulses - p0, 0);
    keys[9] = 1'b0;
    wait_scans(2);
    keys[9] = 1'b1;
    wait_scans(6);
    check("key9 repress", pulses - p0, 1);
    check("key9 code", int'(key_code), 9);
    keys = '0;
    wait_scans(6);

    // Short release does not complete; then reset while pressed.
    keys[6] = 1'b1;
    wait_scans(6);
    p0 = pulses;
    keys[6] = 1'b0;
    repeat (2 * SCAN) @(negedge clk);
    keys[6] = 1'b1;
    wait_scans(6);
    check("glitch release pulses", pulses - p0, 0);
    check("glitch release held", int'(key_held), 1);
    rst = 1'b0;
    @(negedge clk);
    check("midrun reset col", int'(col), 4'b1111);
    check("midrun reset key_valid", int'(key_valid), 0);
    check("midrun reset key_held", int'(key_held), 0);
    check("midrun reset key_code", int'(key_code), 0);
    keys = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_scans(2);

    // Randomized presses, holds and gaps against the model.
    for (int it = 0; it < 24; it++) begin
      k = int'($urandom_range(0, 15));
      keys = '0;
      keys[k] = 1'b1;
      if ($urandom_range(0, 3) == 0) keys[$urandom_range(0, 15)] = 1'b1;
      repeat ($urandom_range(SCAN, 9 * SCAN)) @(negedge clk);
      if ($urandom_range(0, 2) == 0) keys[k] = 1'b0;
      else keys = '0;
      repeat ($urandom_range(SCAN, 7 * SCAN)) @(negedge clk);
    end
    keys = '0;
    wait_scans(6);

    // Long hold of key 15: one pulse, or periodic pulses with auto-repeat.
    p0 = pulses;
    keys[15] = 1'b1;
    wait_scans(30);
`ifdef KEYPAD_REPEAT_EN
    check("long hold pulses", pulses - p0, 4);
`else
    check("long hold pulses", pulses - p0, 1);
`endif
    check("long hold code", int'(key_code), 15);
    p0 = pulses;
    keys = '0;
    wait_scans(8);
    check("after hold pulses", pulses - p0, 0);
    check("after hold held", int'(key_held), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
